score_controller: RTL and testbench

Owns the obstacle-dodger score state and schedules a single shared, multi-cycle binary-to-BCD converter between two requesters: the live score and the session high score. It counts points and clears or saturates the score. It latches a new high score at game over. It delivers stable BCD digits, with a valid strobe, to the seven-segment decoders downstream.

---
 rtl/score_pkg.sv | 27 ++
 rtl/bcd_dabble_step.sv | 19 +
 rtl/score_controller.sv | 159 +++++++++++++++
 tb/tb_score_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score controller and its BCD converter.
package score_pkg;

    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_W      = 3 * DIGIT_W;
    localparam int unsigned NUM_SHIFTS = 8;
    localparam int unsigned CNT_W      = $clog2(NUM_SHIFTS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] hundreds;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd_t;

    // Double-dabble correction: a nibble of 5 or more must carry after the shift.
    function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] n);
        return (n >= DIGIT_W'(5)) ? n + DIGIT_W'(3) : n;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: correct each BCD nibble, then shift in one bit.
module bcd_dabble_step
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] acc_i,
    input  logic             bit_i,
    output logic [BCD_W-1:0] acc_c
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj   = {add3_if_ge5(acc_i[3*DIGIT_W-1:2*DIGIT_W]),
                 add3_if_ge5(acc_i[2*DIGIT_W-1:DIGIT_W]),
                 add3_if_ge5(acc_i[DIGIT_W-1:0])};
        acc_c = {adj[BCD_W-2:0], bit_i};
    end

endmodule

// File: rtl/score_controller.sv
// Score/high-score bookkeeping plus a shared serial binary-to-BCD converter
// that tracks whichever source is currently selected for display.
module score_controller
    import score_pkg::*;
#(
    parameter int unsigned SCORE_MAX = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_start,
    input  logic               point,
    input  logic               game_over,
    input  logic               show_high,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [DIGIT_W-1:0] hundreds,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               digits_valid,
    output logic               busy
);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;
    logic               game_over_q;

    conv_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] snap_q, snap_d;
    logic               snap_src_q, snap_src_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   acc_step;
    bcd_t               digits_q, digits_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [SCORE_W-1:0] last_val_q, last_val_d;
    logic               last_src_q, last_src_d;

    logic [SCORE_W-1:0] req_val;
    logic               dirty;
    logic               snap_bit;

    // Score counting and game-over high-score capture.
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        if (game_start) begin
            score_d = '0;
        end else if (point && !game_over && (score_q < SCORE_W'(SCORE_MAX))) begin
            score_d = score_q + SCORE_W'(1);
        end
        if (game_over && !game_over_q && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
        if (game_start) begin
            new_high_d = 1'b0;
        end
    end

    assign snap_bit = snap_q[CNT_W'(SCORE_W - 1) - cnt_q];

    bcd_dabble_step u_step (
        .acc_i (acc_q),
        .bit_i (snap_bit),
        .acc_c (acc_step)
    );

    // Converter FSM: snapshot on a dirty request, shift MSB first, publish in DONE.
    always_comb begin
        req_val    = show_high ? high_q : score_q;
        dirty      = (req_val != last_val_q) || (show_high != last_src_q);
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        snap_src_d = snap_src_q;
        acc_d      = acc_q;
        digits_d   = digits_q;
        valid_d    = 1'b0;
        last_val_d = last_val_q;
        last_src_d = last_src_q;
        case (state_q)
            IDLE: begin
                if (dirty) begin
                    snap_d     = req_val;
                    snap_src_d = show_high;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_SHIFTS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d   = acc_q;
                valid_d    = 1'b1;
                last_val_d = snap_q;
                last_src_d = snap_src_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            game_over_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            snap_src_q  <= 1'b0;
            acc_q       <= '0;
            digits_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            last_val_q  <= '0;
            last_src_q  <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            game_over_q <= game_over;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            snap_src_q  <= snap_src_d;
            acc_q       <= acc_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            last_val_q  <= last_val_d;
            last_src_q  <= last_src_d;
        end
    end

    assign score        = score_q;
    assign high_score   = high_q;
    assign new_high     = new_high_q;
    assign hundreds     = digits_q.hundreds;
    assign tens         = digits_q.tens;
    assign ones         = digits_q.ones;
    assign digits_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: directed scenarios plus random traffic, checked every cycle
// against a cycle-level behavioural model of scoring and conversion scheduling.
module tb_score_controller;

    localparam int SMAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_start = 1'b0;
    logic       point = 1'b0;
    logic       game_over = 1'b0;
    logic       show_high = 1'b0;
    logic [7:0] score, high_score;
    logic       new_high;
    logic [3:0] hundreds, tens, ones;
    logic       digits_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;

    // Reference model state.
    int m_score, m_high, m_phase, m_snap, m_last_val, m_hund, m_tens, m_ones;
    bit m_new_high, m_go_prev, m_snap_src, m_last_src, m_valid, m_busy;

    score_controller #(.SCORE_MAX(SMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .game_start   (game_start),
        .point        (point),
        .game_over    (game_over),
        .show_high    (show_high),
        .score        (score),
        .high_score   (high_score),
        .new_high     (new_high),
        .hundreds     (hundreds),
        .tens         (tens),
        .ones         (ones),
        .digits_valid (digits_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs sampled at that edge.
    task automatic model_step();
        int ns, nh, req;
        bit nn;
        if (reset) begin
            m_score = 0; m_high = 0; m_new_high = 0; m_go_prev = 0;
            m_phase = 0; m_snap = 0; m_snap_src = 0; m_last_val = 0; m_last_src = 0;
            m_hund = 0; m_tens = 0; m_ones = 0; m_valid = 0; m_busy = 0;
        end else begin
            ns = m_score; nh = m_high; nn = m_new_high;
            if (game_start) ns = 0;
            else if (point && !game_over && m_score < SMAX) ns = m_score + 1;
            if (game_over && !m_go_prev && m_score > m_high) begin
                nh = m_score; nn = 1;
            end
            if (game_start) nn = 0;
            m_valid = 0;
            if (m_phase == 0) begin
                req = show_high ? m_high : m_score;
                if (req != m_last_val || show_high != m_last_src) begin
                    m_snap = req; m_snap_src = show_high; m_phase = 1;
                end
            end else if (m_phase < 9) begin
                m_phase++;
            end else begin
                m_hund = m_snap / 100; m_tens = (m_snap / 10) % 10; m_ones = m_snap % 10;
                m_valid = 1; m_last_val = m_snap; m_last_src = m_snap_src; m_phase = 0;
            end
            m_score = ns; m_high = nh; m_new_high = nn; m_go_prev = game_over;
            m_busy = (m_phase != 0);
        end
    endtask

    task automatic compare_all();
        chk("score", score, m_score);
        chk("high_score", high_score, m_high);
        chk("new_high", new_high, m_new_high);
        chk("hundreds", hundreds, m_hund);
        chk("tens", tens, m_tens);
        chk("ones", ones, m_ones);
        chk("digits_valid", digits_valid, m_valid);
        chk("busy", busy, m_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (digits_valid) valid_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (digits_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        game_start = 1'b1; tick(); game_start = 1'b0;
    endtask

    initial begin
        int n, vc, wrapped, prev;

        // Reset state and eight spaced points.
        reset = 1'b1; tick();
        chk("rst_score", score, 0);
        chk("rst_digits", {hundreds, tens, ones}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0; tick();
        valid_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            point = 1'b1; tick(); point = 1'b0;
            wait_valid(15, n);
            chk("s1_latency", n, 10);
            tick();
        end
        chk("s1_score", score, 8);
        chk("s1_hundreds", hundreds, 0);
        chk("s1_tens", tens, 0);
        chk("s1_ones", ones, 8);
        chk("s1_pulses", valid_cnt, 8);

        // Saturation with point held.
        wrapped = 0; prev = score;
        point = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (score < prev) wrapped = 1;
            prev = score;
        end
        point = 1'b0; ticks(25);
        chk("s2_nowrap", wrapped, 0);
        chk("s2_score", score, 255);
        chk("s2_hundreds", hundreds, 2);
        chk("s2_tens", tens, 5);
        chk("s2_ones", ones, 5);

        // High score capture at game over.
        pulse_start();
        point = 1'b1; ticks(137); point = 1'b0; ticks(25);
        game_over = 1'b1; show_high = 1'b1; ticks(25);
        chk("s3_high", high_score, 137);
        chk("s3_new_high", new_high, 1);
        chk("s3_digits", hundreds * 100 + tens * 10 + ones, 137);
        game_over = 1'b0; tick();
        pulse_start();
        chk("s3_clr_score", score, 0);
        chk("s3_clr_new_high", new_high, 0);
        chk("s3_keep_high", high_score, 137);
        show_high = 1'b0; ticks(25);

        // Burst of points while the converter is busy.
        point = 1'b1; ticks(5); point = 1'b0;
        wait_valid(20, n);
        chk("s4_first_found", int'(n > 0), 1);
        chk("s4_first", hundreds * 100 + tens * 10 + ones, 1);
        wait_valid(20, n);
        chk("s4_second_found", int'(n > 0), 1);
        chk("s4_final", hundreds * 100 + tens * 10 + ones, 5);

        // game_start beats a simultaneous point.
        pulse_start();
        point = 1'b1; ticks(40); point = 1'b0; ticks(25);
        chk("s5_score40", score, 40);
        game_start = 1'b1; point = 1'b1; tick(); game_start = 1'b0; point = 1'b0;
        chk("s5_score", score, 0);
        ticks(25);
        chk("s5_digits", hundreds * 100 + tens * 10 + ones, 0);

        // Reset during the fourth shift of a conversion of 99.
        point = 1'b1; ticks(98); point = 1'b0; ticks(25);
        chk("s6_pre", hundreds * 100 + tens * 10 + ones, 98);
        point = 1'b1; tick(); point = 1'b0;
        ticks(4);
        vc = valid_cnt;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("s6_score", score, 0);
        chk("s6_digits", hundreds * 100 + tens * 10 + ones, 0);
        chk("s6_busy", busy, 0);
        chk("s6_valid", digits_valid, 0);
        ticks(15);
        chk("s6_no_pulse", valid_cnt - vc, 0);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            point      = 1'($urandom_range(0, 1));
            game_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) game_over = ~game_over;
            if ($urandom_range(0, 29) == 0) show_high = ~show_high;
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        point = 1'b0; game_start = 1'b0; reset = 1'b0;
        ticks(25);
        chk("rand_converge", hundreds * 100 + tens * 10 + ones,
            show_high ? m_high : m_score);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
